// File: rtl/gpu_net_ni_if.sv
// Flit handshake bundle between the GPU, the network interface and the router local port.
// The slave modport is the network interface. The master modport is the GPU/router side.
interface gpu_net_ni_if;
  logic [15:0] gpu_data_in;
  logic        gpu_valid_in;
  logic        gpu_ready_out;
  logic [15:0] gpu_data_out;
  logic        gpu_valid_out;
  logic        gpu_ready_in;
  logic [15:0] rt_data_out;
  logic        rt_valid_out;
  logic        rt_ready_in;
  logic [15:0] rt_data_in;
  logic        rt_valid_in;
  logic        rt_ready_out;

  modport slave (
    input  gpu_data_in, gpu_valid_in, gpu_ready_in, rt_ready_in, rt_data_in, rt_valid_in,
    output gpu_ready_out, gpu_data_out, gpu_valid_out, rt_data_out, rt_valid_out, rt_ready_out
  );

  modport master (
    output gpu_data_in, gpu_valid_in, gpu_ready_in, rt_ready_in, rt_data_in, rt_valid_in,
    input  gpu_ready_out, gpu_data_out, gpu_valid_out, rt_data_out, rt_valid_out, rt_ready_out
  );
endinterface

// File: rtl/gpu_net_ni.sv
// GPU-side network interface with two FWFT FIFOs.
// INJ carries GPU flits to the router and drops self-addressed flits; EJ carries router flits to the GPU and drops misrouted ones.
module gpu_net_ni #(
  parameter int GPU_ID     = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  gpu_net_ni_if.slave                   bus,
  output logic [CNT_W-1:0]              self_drop_cnt,
  output logic [CNT_W-1:0]              misroute_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   inj_level,
  output logic [$clog2(FIFO_DEPTH):0]   ej_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL  = LW'(FIFO_DEPTH);
  localparam logic [5:0]    MY_ID = 6'(GPU_ID);

  logic [15:0]   inj_mem [FIFO_DEPTH];
  logic [15:0]   ej_mem  [FIFO_DEPTH];
  logic [AW-1:0] inj_wp, inj_rp, ej_wp, ej_rp;
  logic [LW-1:0] inj_lvl, ej_lvl;

  logic inj_full, inj_empty, ej_full, ej_empty;
  logic gpu_hs, rt_hs, self_hit, for_me;
  logic inj_push, inj_pop, ej_push, ej_pop;

  assign inj_full  = inj_lvl == FULL;
  assign inj_empty = inj_lvl == '0;
  assign ej_full   = ej_lvl == FULL;
  assign ej_empty  = ej_lvl == '0;

  // Readies come only from registered levels and reset, so no valid-to-ready path exists.
  assign bus.gpu_ready_out = !ARESET && !inj_full;
  assign bus.rt_ready_out  = !ARESET && !ej_full;

  assign bus.rt_valid_out  = !ARESET && !inj_empty;
  assign bus.rt_data_out   = bus.rt_valid_out ? inj_mem[inj_rp] : '0;
  assign bus.gpu_valid_out = !ARESET && !ej_empty;
  assign bus.gpu_data_out  = bus.gpu_valid_out ? ej_mem[ej_rp] : '0;

  assign gpu_hs   = bus.gpu_valid_in && bus.gpu_ready_out;
  assign rt_hs    = bus.rt_valid_in && bus.rt_ready_out;
  assign self_hit = bus.gpu_data_in[15:10] == MY_ID;
  assign for_me   = bus.rt_data_in[15:10] == MY_ID;

  assign inj_push = gpu_hs && !self_hit;
  assign inj_pop  = bus.rt_valid_out && bus.rt_ready_in;
  assign ej_push  = rt_hs && for_me;
  assign ej_pop   = bus.gpu_valid_out && bus.gpu_ready_in;

  assign inj_level = inj_lvl;
  assign ej_level  = ej_lvl;

  always_ff @(posedge ACLK) begin
    if (inj_push) inj_mem[inj_wp] <= bus.gpu_data_in;
    if (ej_push)  ej_mem[ej_wp]   <= bus.rt_data_in;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      inj_wp        <= '0;
      inj_rp        <= '0;
      inj_lvl       <= '0;
      ej_wp         <= '0;
      ej_rp         <= '0;
      ej_lvl        <= '0;
      self_drop_cnt <= '0;
      misroute_cnt  <= '0;
    end else begin
      if (inj_push) inj_wp <= inj_wp + AW'(1);
      if (inj_pop)  inj_rp <= inj_rp + AW'(1);
      if (inj_push && !inj_pop)      inj_lvl <= inj_lvl + LW'(1);
      else if (!inj_push && inj_pop) inj_lvl <= inj_lvl - LW'(1);

      if (ej_push) ej_wp <= ej_wp + AW'(1);
      if (ej_pop)  ej_rp <= ej_rp + AW'(1);
      if (ej_push && !ej_pop)      ej_lvl <= ej_lvl + LW'(1);
      else if (!ej_push && ej_pop) ej_lvl <= ej_lvl - LW'(1);

      // Drop counters stick at all-ones rather than wrapping.
      if (gpu_hs && self_hit && self_drop_cnt != '1) self_drop_cnt <= self_drop_cnt + CNT_W'(1);
      if (rt_hs && !for_me && misroute_cnt != '1)    misroute_cnt  <= misroute_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_gpu_net_ni.sv
// Directed self-checking bench for gpu_net_ni (GPU_ID=9, FIFO_DEPTH=4, CNT_W=8).
module tb_gpu_net_ni;
  logic       ACLK = 1'b0;
  logic       ARESET;
  logic [7:0] self_drop_cnt, misroute_cnt;
  logic [2:0] inj_level, ej_level;
  int errors = 0;
  int checks = 0;

  always #5 ACLK = ~ACLK;

  gpu_net_ni_if bus();

  gpu_net_ni #(.GPU_ID(9), .FIFO_DEPTH(4), .CNT_W(8)) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .bus(bus.slave),
    .self_drop_cnt(self_drop_cnt),
    .misroute_cnt(misroute_cnt),
    .inj_level(inj_level),
    .ej_level(ej_level)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    step();
    step();
    checks++;
    if ({bus.gpu_valid_out, bus.rt_valid_out, bus.gpu_ready_out, bus.rt_ready_out} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000",
               {bus.gpu_valid_out, bus.rt_valid_out, bus.gpu_ready_out, bus.rt_ready_out});
    end
    checks++;
    if ({self_drop_cnt, misroute_cnt, inj_level, ej_level} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL reset_counts: got sd=%0d mr=%0d il=%0d el=%0d expected all 0",
               self_drop_cnt, misroute_cnt, inj_level, ej_level);
    end
    checks++;
    if ({bus.gpu_data_out, bus.rt_data_out} !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h %h expected 0000 0000", bus.gpu_data_out, bus.rt_data_out);
    end
    ARESET = 1'b0;
    #1;
    checks++;
    if ({bus.gpu_valid_out, bus.rt_valid_out, bus.gpu_ready_out, bus.rt_ready_out} !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL release_flags: got %b expected 0011",
               {bus.gpu_valid_out, bus.rt_valid_out, bus.gpu_ready_out, bus.rt_ready_out});
    end
    step();
  endtask

  task automatic test_single_inject();
    bus.rt_ready_in  = 1'b0;
    bus.gpu_data_in  = 16'h2923;
    bus.gpu_valid_in = 1'b1;
    step();
    bus.gpu_valid_in = 1'b0;
    checks++;
    if ({bus.rt_valid_out, bus.rt_data_out} !== {1'b1, 16'h2923}) begin
      errors++;
      $display("[TB] FAIL single_latency: got v=%b d=%h expected v=1 d=2923", bus.rt_valid_out, bus.rt_data_out);
    end
    step();
    checks++;
    if ({bus.rt_valid_out, bus.rt_data_out} !== {1'b1, 16'h2923}) begin
      errors++;
      $display("[TB] FAIL single_hold: got v=%b d=%h expected v=1 d=2923", bus.rt_valid_out, bus.rt_data_out);
    end
    bus.rt_ready_in = 1'b1;
    step();
    checks++;
    if (bus.rt_valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pop: got v=%b expected v=0", bus.rt_valid_out);
    end
    bus.rt_ready_in = 1'b0;
  endtask

  task automatic test_inj_full();
    int got;
    int waited;
    bit accept;
    bit pop;
    logic [15:0] popped;
    bus.rt_ready_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.gpu_data_in  = 16'h0400 + 16'(i);
      bus.gpu_valid_in = 1'b1;
      waited = 0;
      while (!bus.gpu_ready_out && waited < 10) begin
        step();
        waited++;
      end
      step();
    end
    bus.gpu_data_in = 16'h0405;
    step();
    step();
    checks++;
    if ({inj_level, bus.gpu_ready_out} !== {3'd4, 1'b0}) begin
      errors++;
      $display("[TB] FAIL inj_full: got level=%0d ready=%b expected level=4 ready=0", inj_level, bus.gpu_ready_out);
    end
    bus.rt_ready_in = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      accept = bus.gpu_valid_in && bus.gpu_ready_out;
      pop    = bus.rt_valid_out && bus.rt_ready_in;
      popped = bus.rt_data_out;
      step();
      if (accept) bus.gpu_valid_in = 1'b0;
      if (pop) begin
        checks++;
        if (popped !== 16'h0400 + 16'(got + 1)) begin
          errors++;
          $display("[TB] FAIL inj_order: got %h expected %h", popped, 16'h0400 + 16'(got + 1));
        end
        got++;
      end
    end
    checks++;
    if (got !== 5) begin
      errors++;
      $display("[TB] FAIL inj_drain_count: got %0d expected 5", got);
    end
    bus.gpu_valid_in = 1'b0;
    bus.rt_ready_in  = 1'b0;
  endtask

  task automatic test_ej_filter();
    bus.gpu_ready_in = 1'b0;
    bus.rt_valid_in  = 1'b1;
    bus.rt_data_in   = 16'h2555;
    step();
    bus.rt_data_in = 16'h2C01;
    step();
    bus.rt_valid_in = 1'b0;
    checks++;
    if ({bus.gpu_valid_out, bus.gpu_data_out, ej_level} !== {1'b1, 16'h2555, 3'd1}) begin
      errors++;
      $display("[TB] FAIL ej_filter: got v=%b d=%h lvl=%0d expected v=1 d=2555 lvl=1",
               bus.gpu_valid_out, bus.gpu_data_out, ej_level);
    end
    checks++;
    if (misroute_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL misroute_cnt: got %0d expected 1", misroute_cnt);
    end
    bus.gpu_ready_in = 1'b1;
    step();
    checks++;
    if ({bus.gpu_valid_out, ej_level} !== {1'b0, 3'd0}) begin
      errors++;
      $display("[TB] FAIL ej_pop: got v=%b lvl=%0d expected v=0 lvl=0", bus.gpu_valid_out, ej_level);
    end
    bus.gpu_ready_in = 1'b0;
  endtask

  task automatic test_self_drop();
    bit rose = 1'b0;
    bus.gpu_data_in  = 16'h2400;
    bus.gpu_valid_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.rt_valid_out) rose = 1'b1;
      if (i == 99) begin
        checks++;
        if (self_drop_cnt !== 8'd100) begin
          errors++;
          $display("[TB] FAIL self_drop_mid: got %0d expected 100", self_drop_cnt);
        end
      end
    end
    bus.gpu_valid_in = 1'b0;
    checks++;
    if (self_drop_cnt !== 8'd255) begin
      errors++;
      $display("[TB] FAIL self_drop_sat: got %0d expected 255", self_drop_cnt);
    end
    checks++;
    if (rose !== 1'b0) begin
      errors++;
      $display("[TB] FAIL self_drop_leak: got rt_valid_out rose=%b expected 0", rose);
    end
  endtask

  task automatic test_back_to_back();
    int tx = 0;
    int rx = 0;
    int pops = 0;
    int pushes = 0;
    bit lvl_bad = 1'b0;
    bit push;
    bit pop;
    logic [15:0] popped;
    bus.gpu_ready_in = 1'b0;
    bus.rt_valid_in  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rt_data_in = 16'h2400 + 16'(tx);
      step();
      tx++;
    end
    checks++;
    if ({ej_level, bus.rt_ready_out} !== {3'd4, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ej_full: got lvl=%0d ready=%b expected lvl=4 ready=0", ej_level, bus.rt_ready_out);
    end
    bus.rt_data_in   = 16'h2400 + 16'(tx);
    bus.gpu_ready_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (ej_level < 3'd3 || ej_level > 3'd4) lvl_bad = 1'b1;
      pop    = bus.gpu_valid_out && bus.gpu_ready_in;
      push   = bus.rt_valid_in && bus.rt_ready_out;
      popped = bus.gpu_data_out;
      step();
      if (pop) begin
        checks++;
        if (popped !== 16'h2400 + 16'(rx)) begin
          errors++;
          $display("[TB] FAIL b2b_order: got %h expected %h", popped, 16'h2400 + 16'(rx));
        end
        rx++;
        pops++;
      end
      if (push) begin
        tx++;
        pushes++;
        bus.rt_data_in = 16'h2400 + 16'(tx);
      end
    end
    bus.rt_valid_in = 1'b0;
    checks++;
    if (lvl_bad !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_level: got out-of-range=%b expected 0", lvl_bad);
    end
    checks++;
    if (pops !== 12 || pushes !== 11) begin
      errors++;
      $display("[TB] FAIL b2b_rate: got pops=%0d pushes=%0d expected pops=12 pushes=11", pops, pushes);
    end
    for (int c = 0; c < 10 && rx < tx; c++) begin
      pop    = bus.gpu_valid_out && bus.gpu_ready_in;
      popped = bus.gpu_data_out;
      step();
      if (pop) begin
        checks++;
        if (popped !== 16'h2400 + 16'(rx)) begin
          errors++;
          $display("[TB] FAIL b2b_drain_order: got %h expected %h", popped, 16'h2400 + 16'(rx));
        end
        rx++;
      end
    end
    checks++;
    if (rx !== tx || ej_level !== 3'd0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got rx=%0d lvl=%0d expected rx=%0d lvl=0", rx, ej_level, tx);
    end
    bus.gpu_ready_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.gpu_ready_in = 1'b0;
    bus.rt_ready_in  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.gpu_data_in  = 16'h0801 + 16'(i);
      bus.gpu_valid_in = 1'b1;
      bus.rt_data_in   = 16'h2461 + 16'(i);
      bus.rt_valid_in  = 1'b1;
      step();
    end
    bus.gpu_valid_in = 1'b0;
    bus.rt_valid_in  = 1'b0;
    checks++;
    if ({inj_level, ej_level} !== {3'd3, 3'd3}) begin
      errors++;
      $display("[TB] FAIL mid_fill: got il=%0d el=%0d expected 3 3", inj_level, ej_level);
    end
    ARESET = 1'b1;
    step();
    checks++;
    if ({bus.gpu_valid_out, bus.rt_valid_out, inj_level, ej_level, self_drop_cnt, misroute_cnt} !== 24'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got gv=%b rv=%b il=%0d el=%0d sd=%0d mr=%0d expected all 0",
               bus.gpu_valid_out, bus.rt_valid_out, inj_level, ej_level, self_drop_cnt, misroute_cnt);
    end
    ARESET = 1'b0;
    bus.gpu_ready_in = 1'b1;
    bus.rt_ready_in  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({bus.gpu_valid_out, bus.rt_valid_out, bus.gpu_ready_out, bus.rt_ready_out} !== 4'b0011) begin
        errors++;
        $display("[TB] FAIL mid_stale: got %b expected 0011",
                 {bus.gpu_valid_out, bus.rt_valid_out, bus.gpu_ready_out, bus.rt_ready_out});
      end
    end
  endtask

  initial begin
    ARESET           = 1'b1;
    bus.gpu_data_in  = '0;
    bus.gpu_valid_in = 1'b0;
    bus.gpu_ready_in = 1'b0;
    bus.rt_ready_in  = 1'b0;
    bus.rt_data_in   = '0;
    bus.rt_valid_in  = 1'b0;
    test_reset();
    test_single_inject();
    test_inj_full();
    test_ej_filter();
    test_self_drop();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
